i2c_master: RTL and testbench

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_master.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// i2c_master: single-master I2C byte engine driven by START/WRITE/READ/STOP commands.
// scl/sda are open-drain; every bit is four quarters of DIVIDER clk cycles each.
module i2c_master #(
    parameter int unsigned DIVIDER = 25
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire logic  scl,
    inout  wire logic  sda,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    input  logic [7:0] tx_byte,
    input  logic       master_ack,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       rx_ack,
    output logic       cmd_error,
    output logic       bus_active
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WRITE, S_READ, S_STOP} state_t;
    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_STOP  = 2'd3
    } cmd_t;

    localparam logic [7:0] CNT_LAST = 8'(DIVIDER - 1);

    state_t     state, state_n;
    logic [1:0] q, q_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] bit_idx, bit_n;
    logic [7:0] shreg, sh_n;
    logic       rep_start, rep_n;
    logic       mack_r, mack_n;
    logic       scl_oe, scl_oe_n;
    logic       sda_oe, sda_oe_n;
    logic       done_n, err_n, rx_ack_n, bus_n;
    logic [7:0] rx_byte_n;
    logic [1:0] scl_s, sda_s;
    logic       scl_sync, sda_sync;
    logic       stretch_q, advance, q_end, last_q, sample;

    assign scl       = scl_oe ? 1'b0 : 1'bz;
    assign sda       = sda_oe ? 1'b0 : 1'bz;
    assign scl_sync  = scl_s[1];
    assign sda_sync  = sda_s[1];
    assign cmd_ready = (state == S_IDLE);

    // Two-flop synchronizers for the bus lines, idle-high out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_s <= 2'b11;
            sda_s <= 2'b11;
        end else begin
            scl_s <= {scl_s[0], scl};
            sda_s <= {sda_s[0], sda};
        end
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            q          <= '0;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rep_start  <= 1'b0;
            mack_r     <= 1'b0;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
            done       <= 1'b0;
            cmd_error  <= 1'b0;
            rx_ack     <= 1'b0;
            bus_active <= 1'b0;
            rx_byte    <= '0;
        end else begin
            state      <= state_n;
            q          <= q_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            shreg      <= sh_n;
            rep_start  <= rep_n;
            mack_r     <= mack_n;
            scl_oe     <= scl_oe_n;
            sda_oe     <= sda_oe_n;
            done       <= done_n;
            cmd_error  <= err_n;
            rx_ack     <= rx_ack_n;
            bus_active <= bus_n;
            rx_byte    <= rx_byte_n;
        end
    end

    // Next-state, quarter sequencing and the bus drive for the upcoming cycle.
    always_comb begin
        state_n   = state;
        q_n       = q;
        cnt_n     = cnt;
        bit_n     = bit_idx;
        sh_n      = shreg;
        rep_n     = rep_start;
        mack_n    = mack_r;
        done_n    = 1'b0;
        err_n     = 1'b0;
        rx_ack_n  = rx_ack;
        rx_byte_n = rx_byte;
        bus_n     = bus_active;
        scl_oe_n  = 1'b0;
        sda_oe_n  = sda_oe;

        // Quarters in which scl has just been released and a slave may stretch it.
        stretch_q = (((state == S_WRITE) || (state == S_READ)) && (q == 2'd2))
                 || ((state == S_START) && rep_start && (q == 2'd1))
                 || ((state == S_STOP) && (q == 2'd1));
        // The first two cycles always count: the synchronizer still shows the
        // old low level there, so stalling on it would lengthen every bit.
        advance = !(stretch_q && !scl_sync && (cnt >= 8'd2));
        q_end   = advance && (cnt == CNT_LAST);
        sample  = ((state == S_WRITE) || (state == S_READ)) && (q == 2'd3) && (cnt == '0);

        unique case (state)
            S_START: last_q = (q == (rep_start ? 2'd3 : 2'd2));
            S_STOP:  last_q = (q == 2'd2);
            S_WRITE,
            S_READ:  last_q = (q == 2'd3) && (bit_idx == 4'd8);
            default: last_q = 1'b0;
        endcase

        if (state == S_IDLE) begin
            if (cmd_valid) begin
                q_n   = '0;
                cnt_n = '0;
                bit_n = '0;
                if (cmd_t'(cmd) == CMD_START) begin
                    state_n = S_START;
                    rep_n   = bus_active;
                end else if (!bus_active) begin
                    done_n = 1'b1;
                    err_n  = 1'b1;
                end else begin
                    sh_n   = tx_byte;
                    mack_n = master_ack;
                    unique case (cmd_t'(cmd))
                        CMD_WRITE: state_n = S_WRITE;
                        CMD_READ:  state_n = S_READ;
                        default:   state_n = S_STOP;
                    endcase
                end
            end
        end else begin
            if (sample) begin
                if ((state == S_WRITE) && (bit_idx == 4'd8))
                    rx_ack_n = !sda_sync;
                if ((state == S_READ) && (bit_idx != 4'd8))
                    sh_n = {shreg[6:0], sda_sync};
            end
            if (advance)
                cnt_n = q_end ? '0 : cnt + 8'd1;
            if (q_end) begin
                if (last_q) begin
                    state_n = S_IDLE;
                    q_n     = '0;
                    done_n  = 1'b1;
                    if (state == S_START) bus_n = 1'b1;
                    if (state == S_STOP)  bus_n = 1'b0;
                    if (state == S_READ)  rx_byte_n = shreg;
                end else if (((state == S_WRITE) || (state == S_READ)) && (q == 2'd3)) begin
                    q_n   = '0;
                    bit_n = bit_idx + 4'd1;
                    if (state == S_WRITE)
                        sh_n = {shreg[6:0], 1'b0};
                end else begin
                    q_n = q + 2'd1;
                end
            end
        end

        // Drive for the quarter being entered; idle holds scl low while the bus is owned.
        unique case (state_n)
            S_IDLE: begin
                scl_oe_n = bus_n;
                sda_oe_n = sda_oe;
            end
            S_START: begin
                if (rep_n) begin
                    scl_oe_n = (q_n == 2'd0) || (q_n == 2'd3);
                    sda_oe_n = q_n[1];
                end else begin
                    scl_oe_n = (q_n == 2'd2);
                    sda_oe_n = (q_n != 2'd0);
                end
            end
            S_WRITE: begin
                scl_oe_n = !q_n[1];
                sda_oe_n = (bit_n != 4'd8) && !sh_n[7];
            end
            S_READ: begin
                scl_oe_n = !q_n[1];
                sda_oe_n = (bit_n == 4'd8) && mack_n;
            end
            default: begin
                scl_oe_n = (q_n == 2'd0);
                sda_oe_n = (q_n != 2'd2);
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench for i2c_master with a small I2C slave model on the bus.
module tb_i2c_master;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic [7:0] tx_byte = 8'h00;
    logic       master_ack = 1'b0;
    logic       cmd_ready, done, rx_ack, cmd_error, bus_active;
    logic [7:0] rx_byte;

    wire scl;
    wire sda;
    pullup (scl);
    pullup (sda);

    // Slave model state
    logic       slv_scl_low = 1'b0;
    logic       slv_sda_low = 1'b0;
    int         slv_mode = 0;          // 0 passive, 1 ack writes, 2 send slv_byte
    logic [7:0] slv_byte = 8'h00;
    logic       stretch_en = 1'b0;
    int         arm_id = 0;
    int         last_arm = 0;
    int         fall_cnt = 0;
    int         hold = 0;
    int         cyc = 0;
    int         t_f3 = 0, t_f4 = 0;
    int         start_cnt = 0, stop_cnt = 0, low_cnt = 0;
    logic [8:0] cap = '0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic [7:0] rd_next;

    int n_checks = 0;
    int n_pass = 0;
    int lat = 0;
    logic last_err = 1'b0;

    assign scl = slv_scl_low ? 1'b0 : 1'bz;
    assign sda = slv_sda_low ? 1'b0 : 1'bz;
    assign rd_next = slv_byte << (fall_cnt + 1);

    i2c_master #(.DIVIDER(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (scl),
        .sda        (sda),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .cmd_ready  (cmd_ready),
        .tx_byte    (tx_byte),
        .master_ack (master_ack),
        .done       (done),
        .rx_byte    (rx_byte),
        .rx_ack     (rx_ack),
        .cmd_error  (cmd_error),
        .bus_active (bus_active)
    );

    always #5 clk = ~clk;

    // Bus monitor and slave: edge capture, START/STOP detection, ACK/data and stretching.
    always @(negedge clk) begin
        cyc      <= cyc + 1;
        prev_scl <= scl;
        prev_sda <= sda;
        if (!scl || !sda) low_cnt <= low_cnt + 1;
        if (prev_scl && scl && prev_sda && !sda) start_cnt <= start_cnt + 1;
        if (prev_scl && scl && !prev_sda && sda) stop_cnt <= stop_cnt + 1;
        if (arm_id != last_arm) begin
            last_arm    <= arm_id;
            fall_cnt    <= 0;
            cap         <= '0;
            t_f3        <= 0;
            t_f4        <= 0;
            hold        <= 0;
            slv_scl_low <= 1'b0;
            slv_sda_low <= (slv_mode == 2) && !slv_byte[7];
        end else begin
            if (!prev_scl && scl) cap <= {cap[7:0], sda};
            if (hold > 1) hold <= hold - 1;
            else if (hold == 1) begin
                hold        <= 0;
                slv_scl_low <= 1'b0;
            end
            if (prev_scl && !scl) begin
                fall_cnt <= fall_cnt + 1;
                if (fall_cnt == 2) t_f3 <= cyc;
                if (fall_cnt == 3) t_f4 <= cyc;
                if (slv_mode == 1) slv_sda_low <= (fall_cnt == 7);
                if (slv_mode == 2) slv_sda_low <= (fall_cnt < 7) && !rd_next[7];
                if (stretch_en && (fall_cnt == 2)) begin
                    slv_scl_low <= 1'b1;
                    hold        <= 2 * DIV + 50;
                end
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic arm(input int mode, input logic [7:0] b, input logic st);
        slv_mode   = mode;
        slv_byte   = b;
        stretch_en = st;
        @(posedge clk);
        #1 arm_id = arm_id + 1;
        @(negedge clk);
        #1;
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] c, input logic [7:0] d, input logic ma);
        @(negedge clk);
        cmd        = c;
        tx_byte    = d;
        master_ack = ma;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        last_err = cmd_error;
        check({tag, "_done"}, int'(done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s0, p0, l0, dcnt;

        // Reset state, checked while reset is held
        repeat (3) @(negedge clk);
        check("rst_scl", int'(scl), 1);
        check("rst_sda", int'(sda), 1);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_bus", int'(bus_active), 0);
        check("rst_rx_byte", int'(rx_byte), 8'h00);
        check("rst_done", int'(done), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // WRITE with the bus idle is rejected without touching the bus
        l0 = low_cnt;
        run_cmd("err_wr", 2'd1, 8'hFF, 1'b0);
        check("err_wr_lat", lat, 1);
        check("err_wr_err", int'(last_err), 1);
        repeat (5) @(negedge clk);
        check("err_wr_bus_quiet", low_cnt - l0, 0);
        check("err_wr_ready", int'(cmd_ready), 1);

        // START from idle
        s0 = start_cnt;
        arm(0, 8'h00, 1'b0);
        run_cmd("start", 2'd0, 8'h00, 1'b0);
        check("start_lat", lat, 3 * DIV + 1);
        check("start_err", int'(last_err), 0);
        check("start_bus", int'(bus_active), 1);
        check("start_cond", start_cnt - s0, 1);

        // WRITE 0xA5, slave ACKs
        s0 = start_cnt; p0 = stop_cnt;
        arm(1, 8'h00, 1'b0);
        run_cmd("wr_a5", 2'd1, 8'hA5, 1'b0);
        check("wr_a5_lat", lat, 36 * DIV + 1);
        check("wr_a5_bits", int'(cap[8:1]), 8'hA5);
        check("wr_a5_bit9", int'(cap[0]), 0);
        check("wr_a5_rx_ack", int'(rx_ack), 1);
        check("wr_a5_err", int'(last_err), 0);
        check("wr_a5_no_cond", (start_cnt - s0) + (stop_cnt - p0), 0);

        // WRITE 0x3C, no slave ACK: bit 9 must float high
        arm(0, 8'h00, 1'b0);
        run_cmd("wr_nak", 2'd1, 8'h3C, 1'b0);
        check("wr_nak_bits", int'(cap[8:1]), 8'h3C);
        check("wr_nak_bit9", int'(cap[0]), 1);
        check("wr_nak_rx_ack", int'(rx_ack), 0);

        // READ 0x3C with master NACK
        arm(2, 8'h3C, 1'b0);
        run_cmd("rd_3c", 2'd2, 8'h00, 1'b0);
        check("rd_3c_lat", lat, 36 * DIV + 1);
        check("rd_3c_byte", int'(rx_byte), 8'h3C);
        check("rd_3c_bit9", int'(cap[0]), 1);
        check("rd_3c_err", int'(last_err), 0);

        // READ 0x81 with master ACK
        arm(2, 8'h81, 1'b0);
        run_cmd("rd_81", 2'd2, 8'h00, 1'b1);
        check("rd_81_byte", int'(rx_byte), 8'h81);
        check("rd_81_bit9", int'(cap[0]), 0);

        // WRITE 0x5A with a 50-cycle stretch in bit 3 Q2
        s0 = start_cnt; p0 = stop_cnt;
        arm(1, 8'h00, 1'b1);
        run_cmd("wr_str", 2'd1, 8'h5A, 1'b0);
        check("wr_str_bit3_len", int'((t_f4 - t_f3) >= 4 * DIV + 50 && (t_f4 - t_f3) <= 4 * DIV + 52), 1);
        check("wr_str_bits", int'(cap[8:1]), 8'h5A);
        check("wr_str_no_cond", (start_cnt - s0) + (stop_cnt - p0), 0);
        check("wr_str_rx_ack", int'(rx_ack), 1);

        // Repeated START
        s0 = start_cnt; p0 = stop_cnt;
        arm(0, 8'h00, 1'b0);
        run_cmd("rstart", 2'd0, 8'h00, 1'b0);
        check("rstart_cond", start_cnt - s0, 1);
        check("rstart_no_stop", stop_cnt - p0, 0);
        check("rstart_bus", int'(bus_active), 1);
        check("rstart_err", int'(last_err), 0);

        // STOP
        p0 = stop_cnt;
        run_cmd("stop", 2'd3, 8'h00, 1'b0);
        check("stop_lat", lat, 3 * DIV + 1);
        check("stop_cond", stop_cnt - p0, 1);
        check("stop_bus", int'(bus_active), 0);
        check("stop_err", int'(last_err), 0);
        repeat (3) @(negedge clk);
        check("stop_scl_rel", int'(scl), 1);
        check("stop_sda_rel", int'(sda), 1);

        // STOP with bus idle is an error
        run_cmd("err_stop", 2'd3, 8'h00, 1'b0);
        check("err_stop_lat", lat, 1);
        check("err_stop_err", int'(last_err), 1);

        // Reset in the middle of a WRITE of 0x00
        run_cmd("start2", 2'd0, 8'h00, 1'b0);
        @(negedge clk);
        cmd       = 2'd1;
        tx_byte   = 8'h00;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (33) @(posedge clk);
        #2;
        check("mid_scl_low", int'(scl), 0);
        check("mid_sda_low", int'(sda), 0);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_scl", int'(scl), 1);
        check("mid_rst_sda", int'(sda), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        dcnt = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("mid_rst_no_done", dcnt, 0);
        check("mid_rst_ready", int'(cmd_ready), 1);
        check("mid_rst_bus", int'(bus_active), 0);
        check("mid_rst_rx_byte", int'(rx_byte), 8'h00);
        check("mid_rst_rx_ack", int'(rx_ack), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
